// File: rtl/rom_arb_pkg.sv
// Shared constants and owner encoding for the two-port ROM arbiter.
// The starvation guard depth default lives here so every build agrees on it.
package rom_arb_pkg;

  localparam int ROM_ADDR_W       = 12;
  localparam int ROM_DATA_W       = 8;
  localparam int DEFAULT_MAX_WAIT = 4;

  // Owner of the read whose data returns from the ROM this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

endpackage : rom_arb_pkg

// File: rtl/rom_arb_starve_ctr.sv
// Port B wait counter: counts denied request cycles, raises override at MAX_WAIT.
// Latency: override is combinational from the registered count and b_req; only built under ROM_ARB_STARVE_GUARD_EN.
// Backpressure: none of its own; override forces one B grant and the count clears on that grant.
module rom_arb_starve_ctr
  import rom_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_req,
  input  logic b_gnt,
  output logic override
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  // Saturates at MAX_WAIT so a long A burst cannot wrap the count back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!b_req || b_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign override = b_req && (wait_cnt == CW'(MAX_WAIT));

endmodule : rom_arb_starve_ctr

// File: rtl/rom_arbiter.sv
// Two-port arbiter for a 1-cycle synchronous ROM; A has priority, optional B starvation guard (ROM_ARB_STARVE_GUARD_EN).
// Latency: grant combinational in the request cycle, rvalid/rdata one cycle later.
// Backpressure: a denied requester holds req/addr until gnt; withdrawn requests produce no return.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  logic              override;
  logic [ADDR_W-1:0] last_addr;
  owner_t            owner_q;

`ifdef ROM_ARB_STARVE_GUARD_EN
  rom_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .b_req    (b_req),
    .b_gnt    (b_gnt),
    .override (override)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
  assign override        = 1'b0;
`endif

  // Grants are forced low during reset so nothing reaches the ROM mid-reset
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (b_req && (!a_req || override)) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr = last_addr;
    if (b_gnt) begin
      rom_addr = b_addr;
    end else if (a_gnt) begin
      rom_addr = a_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      owner_q   <= OWN_NONE;
    end else begin
      if (a_gnt || b_gnt) begin
        last_addr <= rom_addr;
      end
      if (a_gnt) begin
        owner_q <= OWN_A;
      end else if (b_gnt) begin
        owner_q <= OWN_B;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  assign a_rvalid = (owner_q == OWN_A);
  assign b_rvalid = (owner_q == OWN_B);
  assign a_rdata  = rom_dout;
  assign b_rdata  = rom_dout;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: per-cycle vector table plus starvation and reset-mid-read sequences.
// Expectations adapt to whether ROM_ARB_STARVE_GUARD_EN is defined for the build.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [11:0] a_addr, b_addr;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic [11:0] rom_addr;
  logic [7:0]  rom_dout;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_addr   (a_addr),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  // ROM image: ROM[0] = 0x4C, other bytes distinct enough to catch steering errors
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h4C;
  endfunction

  always @(posedge clk) rom_dout <= rom_f(rom_addr);

  typedef struct {
    logic        a_req;
    logic [11:0] a_addr;
    logic        b_req;
    logic [11:0] b_addr;
    logic        e_a_gnt;
    logic        e_b_gnt;
    logic [11:0] e_rom;
    logic        e_a_rv;
    logic        e_b_rv;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic ar, input logic [11:0] aa, input logic br, input logic [11:0] ba,
                     input logic eag, input logic ebg, input logic [11:0] erom,
                     input logic earv, input logic ebrv, input logic [7:0] erd);
    vec_t v;
    v.a_req = ar;  v.a_addr = aa;  v.b_req = br;  v.b_addr = ba;
    v.e_a_gnt = eag; v.e_b_gnt = ebg; v.e_rom = erom;
    v.e_a_rv = earv; v.e_b_rv = ebrv; v.e_rd = erd;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, sample one time unit before the rising edge
  task automatic drive(input logic ar, input logic [11:0] aa, input logic br, input logic [11:0] ba);
    @(negedge clk);
    a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
    #4;
    n_vec++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 12'h123;
    b_req = 1'b1; b_addr = 12'h456;
    #3;
    n_vec++;
    chk("reset a_gnt", a_gnt, 0);
    chk("reset b_gnt", b_gnt, 0);
    chk("reset a_rvalid", a_rvalid, 0);
    chk("reset b_rvalid", b_rvalid, 0);
    chk("reset rom_addr", rom_addr, 12'h000);
    @(negedge clk);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;

    //   a_req a_addr  b_req b_addr  a_gnt b_gnt rom     a_rv b_rv rdata
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h000,  0, 0, 8'h00);        // idle after reset
    add(1, 12'h000, 0, 12'h000,  1, 0, 12'h000,  0, 0, 8'h00);        // uncontended A
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h000,  1, 0, 8'h4C);
    add(1, 12'h010, 1, 12'h020,  1, 0, 12'h010,  0, 0, 8'h00);        // contention, A wins
    add(0, 12'h000, 1, 12'h020,  0, 1, 12'h020,  1, 0, rom_f(12'h010));
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h020,  0, 1, rom_f(12'h020));
    add(1, 12'h100, 0, 12'h000,  1, 0, 12'h100,  0, 0, 8'h00);        // back-to-back A
    add(1, 12'h101, 0, 12'h000,  1, 0, 12'h101,  1, 0, rom_f(12'h100));
    add(1, 12'h102, 0, 12'h000,  1, 0, 12'h102,  1, 0, rom_f(12'h101));
    add(1, 12'h103, 0, 12'h000,  1, 0, 12'h103,  1, 0, rom_f(12'h102));
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h103,  1, 0, rom_f(12'h103));
    add(0, 12'h000, 1, 12'h0FF,  0, 1, 12'h0FF,  0, 0, 8'h00);        // B then idle hold
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h0FF,  0, 1, rom_f(12'h0FF));
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h0FF,  0, 0, 8'h00);
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h0FF,  0, 0, 8'h00);
    add(1, 12'h200, 1, 12'h300,  1, 0, 12'h200,  0, 0, 8'h00);        // B withdraws while denied
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h200,  1, 0, rom_f(12'h200));
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h200,  0, 0, 8'h00);
    add(0, 12'h000, 1, 12'h0AB,  1'b0, 1, 12'h0AB, 0, 0, 8'h00);      // B then A alternate
    add(1, 12'h0CD, 0, 12'h000,  1, 0, 12'h0CD,  0, 1, rom_f(12'h0AB));
    add(0, 12'h000, 0, 12'h000,  0, 0, 12'h0CD,  1, 0, rom_f(12'h0CD));

    foreach (vt[i]) begin
      drive(vt[i].a_req, vt[i].a_addr, vt[i].b_req, vt[i].b_addr);
      chk($sformatf("v%0d a_gnt", i), a_gnt, vt[i].e_a_gnt);
      chk($sformatf("v%0d b_gnt", i), b_gnt, vt[i].e_b_gnt);
      chk($sformatf("v%0d rom_addr", i), rom_addr, vt[i].e_rom);
      chk($sformatf("v%0d a_rvalid", i), a_rvalid, vt[i].e_a_rv);
      chk($sformatf("v%0d b_rvalid", i), b_rvalid, vt[i].e_b_rv);
      if (vt[i].e_a_rv) chk($sformatf("v%0d a_rdata", i), a_rdata, vt[i].e_rd);
      if (vt[i].e_b_rv) chk($sformatf("v%0d b_rdata", i), b_rdata, vt[i].e_rd);
    end

    // Starvation: A requests continuously, B requests from cycle 0
`ifdef ROM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 12'h011, 1'b1, 12'h022);
      chk($sformatf("starve c%0d a_gnt", c), a_gnt, (c == 4) ? 0 : 1);
      chk($sformatf("starve c%0d b_gnt", c), b_gnt, (c == 4) ? 1 : 0);
      chk($sformatf("starve c%0d rom_addr", c), rom_addr, (c == 4) ? 12'h022 : 12'h011);
      if (c == 5) begin
        chk("starve b_rvalid", b_rvalid, 1);
        chk("starve a_rvalid", a_rvalid, 0);
        chk("starve b_rdata", b_rdata, rom_f(12'h022));
      end
    end
`else
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 12'h011, 1'b1, 12'h022);
      chk($sformatf("starve c%0d a_gnt", c), a_gnt, 1);
      chk($sformatf("starve c%0d b_gnt", c), b_gnt, 0);
    end
`endif
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    chk("starve end a_rvalid", a_rvalid, 1);
    chk("starve end rdata", a_rdata, rom_f(12'h011));

    // Reset mid-read: grant A, then assert reset during the return cycle
    drive(1'b1, 12'h050, 1'b0, 12'h000);
    chk("rst seq a_gnt", a_gnt, 1);
    @(negedge clk);
    a_req = 1'b0;
    #2;
    n_vec++;
    chk("rst seq a_rvalid before", a_rvalid, 1);
    rst_n = 1'b0;
    a_req = 1'b1; a_addr = 12'h060;
    b_req = 1'b1; b_addr = 12'h070;
    #1;
    n_vec++;
    chk("rst seq a_rvalid async", a_rvalid, 0);
    chk("rst seq a_gnt in reset", a_gnt, 0);
    chk("rst seq b_gnt in reset", b_gnt, 0);
    @(negedge clk);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    #4;
    n_vec++;
    chk("rst rel a_rvalid", a_rvalid, 0);
    chk("rst rel b_rvalid", b_rvalid, 0);
    chk("rst rel rom_addr", rom_addr, 12'h000);
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    chk("rst rel2 a_rvalid", a_rvalid, 0);
    chk("rst rel2 b_rvalid", b_rvalid, 0);
    chk("rst rel2 rom_addr", rom_addr, 12'h000);
    chk("rst rel2 a_gnt", a_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rom_arbiter

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous-read ROM port (1-cycle read latency, e.g. the 4 KiB BASIC image) between two requesters: port A (CPU bus, high priority) and port B (background client such as a ROM checksum/monitor engine). Each port uses a req/gnt handshake and receives an aligned rvalid/rdata return one cycle after grant. The block sits between the requesters and the ROM macro, drives the ROM address, and steers returned data to the owner of each read.

## Interface
- ADDR_W, 12, ROM address width
- DATA_W, 8, ROM data width
- MAX_WAIT, 4, cycles port B may be denied while requesting before it is forced through (starvation guard only)

- clk  in  1  single system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A read request; held with a_addr until a_gnt
- a_addr  in  ADDR_W  port A read address
- a_gnt  out  1  combinational grant to A this cycle
- a_rvalid  out  1  registered; a_rdata valid this cycle
- a_rdata  out  DATA_W  read data for A
- b_req, b_addr, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- rom_addr  out  ADDR_W  address to ROM, sampled by ROM on rising edge
- rom_dout  in  DATA_W  ROM registered read data (valid the cycle after address)

## Operation
- Each cycle at most one grant; a_gnt & b_gnt never both 1.
- Default policy: A wins whenever a_req=1; B granted only when b_req=1 and (a_req=0 or starvation override active).
- rom_addr = winner's address when a grant occurs; otherwise holds last granted address (last_addr register, reset 0). No grant => no read is attributed.
- Return tracking: registered owner flags; on the edge ending a grant cycle, set a_rvalid or b_rvalid for the winner, clear the other; with no grant both clear next cycle.
- a_rdata and b_rdata both driven from rom_dout; meaningful only while the matching rvalid=1.
- Requester drops req, or presents a new address, in the cycle after gnt; req held high after gnt is a new request (back-to-back reads at one per cycle supported).
- Req deasserted before grant is legal: request withdrawn, no return.
- Reset values: a_rvalid=b_rvalid=0, last_addr=0, wait counter=0; a_gnt=b_gnt=0 forced while rst_n=0. Reset mid-read discards the pending return (no rvalid after reset release).

## Timing
- Cycle t: req=1 & gnt=1 (combinational, same cycle), rom_addr=addr.
- Edge t→t+1: ROM captures address; rvalid register set.
- Cycle t+1: rvalid=1, rdata=ROM[addr]. Latency req→data = 1 cycle when uncontended.
- Throughput: one read per cycle total, shared.
- Simultaneous req both ports: A granted (unless override); B's gnt stays 0, B must hold req/addr.

## Configuration
- ROM_ARB_STARVE_GUARD_EN defined: saturating counter wait_cnt (0..MAX_WAIT) increments each cycle b_req=1 & b_gnt=0; cleared when b_gnt=1 or b_req=0. When wait_cnt==MAX_WAIT and b_req=1, B is granted even if a_req=1 (A denied that cycle, counter clears). Worst-case B wait = MAX_WAIT cycles.
- Not defined: strict A priority, counter not built; B may starve indefinitely under continuous a_req.

## Structure
- Package rom_arb_pkg: ROM_ADDR_W/ROM_DATA_W constants, owner enum (OWN_NONE, OWN_A, OWN_B), default MAX_WAIT.
- One natural sub-module: rom_arb_starve_ctr (wait counter + override flag), instantiated only under ROM_ARB_STARVE_GUARD_EN.
- Arbitration, address mux, last_addr and owner/rvalid registers stay in rom_arbiter.

## Test plan
- Uncontended A: a_req=1, a_addr=0x000 for one cycle with ROM[0]=0x4C -> a_gnt=1 same cycle, next cycle a_rvalid=1, a_rdata=0x4C, b_rvalid=0.
- Contention: a_req=b_req=1, a_addr=0x010, b_addr=0x020 for one cycle, then a_req=0 -> cycle 1 a_gnt=1, cycle 2 b_gnt=1 with rom_addr=0x020; rvalids follow in cycles 2 and 3 with correct data.
- Back-to-back: a_req held 4 cycles with addrs 0x100..0x103 -> a_gnt 4 consecutive cycles, a_rvalid 4 consecutive cycles, data matches ROM in order.
- Starvation (macro on, MAX_WAIT=4): a_req=1 continuous, b_req=1 from cycle 0 -> b_gnt=1 in cycle 4 with a_gnt=0 that cycle; macro off -> b_gnt never asserted.
- Reset mid-read: grant A at cycle t, rst_n=0 asynchronously during cycle t+1 -> a_rvalid drops immediately, gnts=0; after release with no req, no rvalid appears and rom_addr=0.
- Idle hold: grant B at 0x0FF then no requests for 3 cycles -> rom_addr stays 0x0FF, both rvalid=0 after the single return.
